mu_issue_ctl: RTL and testbench

//  Issue/writeback controller for the pipelined multiply unit (mu). Accepts M-ext multiply ops from

---
 rtl/mu_issue_ctl_pkg.sv | 31 +++
 rtl/mu_issue_ctl_sync_fifo.sv | 75 +++++++
 rtl/mu_issue_ctl.sv | 131 +++++++++++++
 tb/tb_mu_issue_ctl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mu_issue_ctl_pkg.sv
// Shared definitions for the multiply-unit issue/writeback controller:
// mu control encodings, tag/result entry layouts and a scoreboard helper.
package mu_issue_ctl_pkg;

  localparam int XLEN  = 32;
  localparam int RD_W  = 5;
  localparam int TAG_W = RD_W + 1;       // {kill, rd}
  localparam int RES_W = RD_W + XLEN;    // {rd, data} = 37

  localparam logic [1:0] MULCTL_MUL    = 2'b00;
  localparam logic [1:0] MULCTL_MULH   = 2'b01;
  localparam logic [1:0] MULCTL_MULHSU = 2'b10;
  localparam logic [1:0] MULCTL_MULHU  = 2'b11;

  typedef struct packed {
    logic            kill;
    logic [RD_W-1:0] rd;
  } tag_t;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
  } res_t;

  // A source register has a pending multiply when it is not x0 and its
  // scoreboard bit is set.
  function automatic logic src_pending(input logic [31:0] sb, input logic [RD_W-1:0] r);
    return (r != '0) && sb[r];
  endfunction

endpackage

// File: rtl/mu_issue_ctl_sync_fifo.sv
// Synchronous FIFO with occupancy count, synchronous clear and a bulk
// "mark" that sets the MSB of every stored entry (used as the kill flag).
module mu_issue_ctl_sync_fifo #(
  parameter int W = 8,
  parameter int D = 4,
  localparam int CW = $clog2(D + 1),
  localparam int PW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          mark_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_ok = push_i && (cnt_q != CW'(D));
  assign pop_ok  = pop_i && (cnt_q != '0);
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Next pointers and count; clear empties the FIFO and wins over push/pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = ptr_inc(wr_q);
      if (pop_ok)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage: bulk mark first, then a same-cycle push writes its own entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
    end else if (!clr_i) begin
      if (mark_i) begin
        for (int i = 0; i < D; i++) mem_q[i][W-1] <= 1'b1;
      end
      if (push_ok) mem_q[wr_q] <= din_i;
    end
  end

endmodule

// File: rtl/mu_issue_ctl.sv
// Issue/writeback controller for the pipelined multiply unit. Issues one op
// per cycle, pairs in-order mu results with their destination registers,
// buffers results for the regfile port and keeps a busy scoreboard.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both 1
// at the clock edge; valid never depends on ready of the same interface
// (req_ready and wb_valid are derived from state, flush and req_rd only).
module mu_issue_ctl
  import mu_issue_ctl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [1:0]       req_op,
  input  logic [RD_W-1:0]  req_rd,
  input  logic [RD_W-1:0]  chk_rs1,
  input  logic [RD_W-1:0]  chk_rs2,
  output logic             chk_hazard,
  input  logic             flush,
  output logic             mu_en,
  output logic [XLEN-1:0]  mu_a,
  output logic [XLEN-1:0]  mu_b,
  output logic [1:0]       mu_ctl,
  input  logic [XLEN-1:0]  mu_res,
  input  logic             mu_valid,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RD_W-1:0]  wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   sb_q, sb_d;
  logic          err_q, err_d;
  logic [CW-1:0] tag_cnt, res_cnt;
  logic [CW:0]   occ;
  tag_t          tag_head, tag_in;
  res_t          res_head, res_in;
  logic          tag_empty, res_empty;
  logic          issue, tag_pop, res_push, wb_pop;

  assign tag_empty = (tag_cnt == '0);
  assign res_empty = (res_cnt == '0);
  // Killed tags keep their slot until their result returns, so they count too.
  assign occ       = {1'b0, tag_cnt} + {1'b0, res_cnt};

  assign req_ready = !flush && (occ < (CW + 1)'(DEPTH)) && !src_pending(sb_q, req_rd);
  assign issue     = req_valid && req_ready;

  assign mu_en  = issue;
  assign mu_a   = req_a;
  assign mu_b   = req_b;
  assign mu_ctl = req_op;

  assign tag_in.kill = 1'b0;
  assign tag_in.rd   = req_rd;
  assign tag_pop     = mu_valid && !tag_empty;
  // A result coinciding with flush, or belonging to a killed tag, is dropped.
  assign res_push    = tag_pop && !tag_head.kill && !flush;
  assign res_in.rd   = tag_head.rd;
  assign res_in.data = mu_res;

  assign wb_valid = !flush && !res_empty;
  assign wb_rd    = res_head.rd;
  assign wb_data  = res_head.data;
  assign wb_pop   = wb_valid && wb_ready;

  assign chk_hazard = src_pending(sb_q, chk_rs1) || src_pending(sb_q, chk_rs2);
  assign busy       = !tag_empty || !res_empty;
  assign err        = err_q;

  mu_issue_ctl_sync_fifo #(.W(TAG_W), .D(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (1'b0),
    .mark_i  (flush),
    .push_i  (issue),
    .din_i   (tag_in),
    .pop_i   (tag_pop),
    .dout_o  (tag_head),
    .count_o (tag_cnt)
  );

  mu_issue_ctl_sync_fifo #(.W(RES_W), .D(DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .mark_i  (1'b0),
    .push_i  (res_push),
    .din_i   (res_in),
    .pop_i   (wb_pop),
    .dout_o  (res_head),
    .count_o (res_cnt)
  );

  // Scoreboard: flush clears all; otherwise writeback clears, issue sets.
  always_comb begin
    sb_d = sb_q;
    if (flush) begin
      sb_d = '0;
    end else begin
      if (wb_pop) sb_d[wb_rd] = 1'b0;
      if (issue && (req_rd != '0)) sb_d[req_rd] = 1'b1;
    end
  end

  // Sticky error on a result arriving with no tag to pair it with.
  always_comb begin
    err_d = err_q | (mu_valid && tag_empty);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sb_q  <= sb_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_mu_issue_ctl.sv
// Bench for mu_issue_ctl: a fixed-latency multiply unit model drives the
// result side, and a queue-based reference model predicts ready, hazard,
// busy and the in-order writeback stream.
module tb_mu_issue_ctl;
  import mu_issue_ctl_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [1:0]  req_op;
  logic [4:0]  req_rd, chk_rs1, chk_rs2;
  logic        chk_hazard, flush;
  logic        mu_en;
  logic [31:0] mu_a, mu_b, mu_res;
  logic [1:0]  mu_ctl;
  logic        mu_valid;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy, err;

  mu_issue_ctl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_rd(req_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .chk_hazard(chk_hazard), .flush(flush),
    .mu_en(mu_en), .mu_a(mu_a), .mu_b(mu_b), .mu_ctl(mu_ctl),
    .mu_res(mu_res), .mu_valid(mu_valid),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .err(err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard and model state
  logic [36:0] exp_q[$];    // live ops in issue order: {rd, expected data}
  int          live_ret;    // leading exp_q entries whose result has returned
  int          killed_n;    // flushed ops still owed a result by the mu
  int          cyc;
  bit          chk_en;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] res;
  } mu_ent_t;
  mu_ent_t mu_q[$];         // environment: ops inside the multiply unit

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MULCTL_MUL:    p = ua * ub;
      MULCTL_MULH:   p = sa * sb;
      MULCTL_MULHSU: p = sa * ub;
      default:       p = ua * ub;
    endcase
    return (op == MULCTL_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic bit rd_pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (exp_q[i]) if (exp_q[i][36:32] == r) return 1'b1;
    return 1'b0;
  endfunction

  // Driver: one cycle of stimulus, checks against the model, model advance.
  task automatic step(input bit rv, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit fl, input bit wbr);
    bit      mv, e_ready, e_issue, e_wbv, e_haz, wbp;
    int      occ;
    mu_ent_t ent;
    @(negedge clk);
    req_valid = rv; req_a = a; req_b = b; req_op = op; req_rd = rd;
    chk_rs1 = rs1; chk_rs2 = rs2; flush = fl; wb_ready = wbr;
    mv = (mu_q.size() != 0) && (mu_q[0].due == 32'(cyc));
    mu_valid = mv;
    mu_res = mv ? mu_q[0].res : $urandom;
    #1;
    occ     = mu_q.size() + live_ret;
    e_ready = !fl && (occ < DEPTH) && !rd_pending(rd);
    e_issue = rv && e_ready;
    e_wbv   = !fl && (live_ret > 0);
    e_haz   = rd_pending(rs1) || rd_pending(rs2);
    if (chk_en) begin
      check("req_ready", req_ready, e_ready);
      check("mu_en", mu_en, e_issue);
      if (e_issue) begin
        check("mu_a", mu_a, a);
        check("mu_b", mu_b, b);
        check("mu_ctl", mu_ctl, op);
      end
      check("chk_hazard", chk_hazard, e_haz);
      check("wb_valid", wb_valid, e_wbv);
      if (e_wbv) begin
        check("wb_rd", wb_rd, exp_q[0][36:32]);
        check("wb_data", wb_data, exp_q[0][31:0]);
      end
      check("busy", busy, occ != 0);
      check("err", err, 1'b0);
    end
    wbp = e_wbv && wbr;
    if (mv) void'(mu_q.pop_front());
    if (fl) begin
      killed_n = mu_q.size();
      exp_q.delete();
      live_ret = 0;
    end else begin
      if (mv) begin
        if (killed_n > 0) killed_n--;
        else live_ret++;
      end
      if (wbp) begin
        void'(exp_q.pop_front());
        live_ret--;
      end
      if (e_issue) exp_q.push_back({rd, mul_ref(a, b, op)});
    end
    if (mu_en) begin
      ent.due = 32'(cyc + LAT);
      ent.res = mul_ref(mu_a, mu_b, mu_ctl);
      mu_q.push_back(ent);
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit wbr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, wbr);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (mu_q.size() == 0 && exp_q.size() == 0) break;
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
    check("drain_left", 64'(mu_q.size() + exp_q.size()), 64'd0);
  endtask

  task automatic one_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expd);
    step(1, a, b, op, rd, 0, 0, 0, 0);
    idle(LAT + 1, 0);
    check({tag, "_wb_valid"}, wb_valid, 1'b1);
    check({tag, "_wb_rd"}, wb_rd, rd);
    check({tag, "_wb_data"}, wb_data, expd);
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_a = 0; req_b = 0; req_op = 0; req_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; flush = 0; wb_ready = 0;
    mu_valid = 0; mu_res = 0;
    live_ret = 0; killed_n = 0; cyc = 0; chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mu_en", mu_en, 1'b0);
    #1 rst_n = 1'b1;
    idle(2, 1);

    // Single ops, including high-half variants
    one_op("mul7x6", MULCTL_MUL, 32'd7, 32'd6, 5'd5, 32'd42);
    one_op("mulhu", MULCTL_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd9, 32'd1);
    one_op("mulh", MULCTL_MULH, 32'hFFFF_FFFF, 32'd2, 5'd10, 32'hFFFF_FFFF);
    one_op("mulhsu", MULCTL_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd11, 32'hFFFF_FFFF);

    // Fill to DEPTH with writeback blocked, then drain in order
    for (int r = 1; r <= 4; r++) step(1, 32'(r * 3), 32'(r + 10), MULCTL_MUL, 5'(r), 0, 0, 0, 0);
    step(1, 32'd1, 32'd1, MULCTL_MUL, 5'd6, 0, 0, 0, 0);
    check("full_ready", req_ready, 1'b0);
    idle(LAT + 2, 0);
    check("full_busy", busy, 1'b1);
    drain();

    // Scoreboard hazard and WAW stall
    step(1, 32'd5, 32'd5, MULCTL_MUL, 5'd3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 5'd3, 5'd0, 0, 0);
    check("haz_rs1", chk_hazard, 1'b1);
    step(1, 32'd2, 32'd2, MULCTL_MUL, 5'd3, 5'd0, 5'd3, 0, 0);
    check("waw_stall", req_ready, 1'b0);
    check("haz_rs2", chk_hazard, 1'b1);
    step(0, 0, 0, 0, 0, 5'd4, 5'd0, 0, 0);
    check("haz_none", chk_hazard, 1'b0);
    drain();
    step(0, 0, 0, 0, 0, 5'd3, 5'd0, 0, 1);
    check("haz_cleared", chk_hazard, 1'b0);

    // Flush mid-flight (coincides with the first result), then reuse rd 1
    step(1, 32'd8, 32'd8, MULCTL_MUL, 5'd1, 0, 0, 0, 1);
    step(1, 32'd9, 32'd9, MULCTL_MUL, 5'd2, 0, 0, 0, 1);
    idle(1, 1);
    step(0, 0, 0, 0, 0, 5'd1, 5'd2, 1, 1);
    step(1, 32'd4, 32'd5, MULCTL_MUL, 5'd1, 5'd2, 5'd0, 0, 1);
    check("post_flush_ready", req_ready, 1'b1);
    check("post_flush_sb", chk_hazard, 1'b0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      step($urandom_range(0, 9) < 6, a, b, 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7);
    end
    drain();

    // Reset with two ops in flight; their late results must set err
    step(1, 32'd3, 32'd3, MULCTL_MUL, 5'd1, 5'd1, 5'd2, 0, 0);
    step(1, 32'd4, 32'd4, MULCTL_MUL, 5'd2, 5'd1, 5'd2, 0, 0);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_wb_valid", wb_valid, 1'b0);
    check("mid_rst_hazard", chk_hazard, 1'b0);
    check("mid_rst_err", err, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 0;
    exp_q.delete();
    live_ret = 0;
    killed_n = 0;
    idle(LAT + 3, 1);
    check("late_err", err, 1'b1);
    check("late_busy", busy, 1'b0);
    check("late_wb_valid", wb_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
